// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and widths for the EX/MEM and MEM/WB pipeline slice.
//   XLEN, REG_AW     : default datapath and register-index widths
//   ex_mem_ctrl_t    : EX/MEM control bits {regwrite, memtoreg, memread, memwrite}
//   mem_wb_ctrl_t    : MEM/WB control bits {regwrite, memtoreg}
//   hs_state_e       : data-memory handshake states {IDLE, WAIT}
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memread;
    logic memwrite;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } mem_wb_ctrl_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } hs_state_e;

endpackage

// File: rtl/ex_mem_wb_pipe_dmem_handshake_fsm.sv
// dmem_handshake_fsm: request/acknowledge sequencer for the data-memory port.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   memop_i        : EX/MEM holds a load or store
//   dmem_ack_i     : memory completes the request this cycle
//   dmem_req_o     : request, held from the first memop cycle until ack
//   stall_o        : pipeline freeze while the request is outstanding
module dmem_handshake_fsm
  import pipe_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic memop_i,
  input  logic dmem_ack_i,
  output logic dmem_req_o,
  output logic stall_o
);

  hs_state_e r_state;
  hs_state_e w_state_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The request is raised combinationally in the first memop cycle so a
  // zero-wait memory completes without any stall.
  always_comb begin
    w_state_next = r_state;
    dmem_req_o   = 1'b0;
    stall_o      = 1'b0;
    case (r_state)
      IDLE: begin
        if (memop_i) begin
          dmem_req_o = 1'b1;
          stall_o    = ~dmem_ack_i;
          if (!dmem_ack_i) begin
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        dmem_req_o = 1'b1;
        stall_o    = ~dmem_ack_i;
        if (dmem_ack_i) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// ex_mem_wb_pipe: EX/MEM and MEM/WB pipeline registers of the RV32 core plus
// the data-memory handshake. The whole pipeline freezes while a load/store
// waits for its acknowledge.
// Optional feature macro: PIPE_STALL_CNT_EN adds stall_cnt_o and memop_cnt_o
// (saturating event counters, cleared by reset).
// Ports:
//   clk_i, rst_i                       : clock, asynchronous active-high reset
//   ex_*_i                             : instruction leaving EX (valid, controls, ALU, store data, rd)
//   dmem_req_o/we_o/addr_o/wdata_o     : data-memory request
//   dmem_ack_i, dmem_rdata_i           : data-memory completion and load data
//   stall_o                            : freeze PC, IF/ID, ID/EX
//   ex_mem_regwrite_o/rd_o/alu_o       : EX/MEM forwarding sources
//   mem_wb_regwrite_o/rd_o, wb_data_o  : MEM/WB forwarding and register-file write
module ex_mem_wb_pipe
  import pipe_pkg::*;
#(
  parameter int XLEN   = pipe_pkg::XLEN,
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_valid_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_memtoreg_i,
  input  logic              ex_memread_i,
  input  logic              ex_memwrite_i,
  input  logic [XLEN-1:0]   ex_alu_i,
  input  logic [XLEN-1:0]   ex_rs2_data_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              stall_o,
  output logic              ex_mem_regwrite_o,
  output logic [REG_AW-1:0] ex_mem_rd_o,
  output logic [XLEN-1:0]   ex_mem_alu_o,
  output logic              mem_wb_regwrite_o,
  output logic [REG_AW-1:0] mem_wb_rd_o,
`ifdef PIPE_STALL_CNT_EN
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       memop_cnt_o,
`endif
  output logic [XLEN-1:0]   wb_data_o
);

  ex_mem_ctrl_t      r_ex_mem_ctrl;
  logic [XLEN-1:0]   r_ex_mem_alu;
  logic [XLEN-1:0]   r_ex_mem_wdata;
  logic [REG_AW-1:0] r_ex_mem_rd;

  mem_wb_ctrl_t      r_mem_wb_ctrl;
  logic [REG_AW-1:0] r_mem_wb_rd;
  logic [XLEN-1:0]   r_mem_wb_alu;
  logic [XLEN-1:0]   r_mem_wb_load;

  ex_mem_ctrl_t      w_ex_ctrl;
  logic              w_memop;
  logic              w_req;
  logic              w_stall;

  // A bubble enters as a harmless no-op: every control bit is qualified by valid.
  assign w_ex_ctrl.regwrite = ex_valid_i & ex_regwrite_i;
  assign w_ex_ctrl.memtoreg = ex_valid_i & ex_memtoreg_i;
  assign w_ex_ctrl.memread  = ex_valid_i & ex_memread_i;
  assign w_ex_ctrl.memwrite = ex_valid_i & ex_memwrite_i;

  assign w_memop = r_ex_mem_ctrl.memread | r_ex_mem_ctrl.memwrite;

  dmem_handshake_fsm u_hs (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .memop_i    (w_memop),
    .dmem_ack_i (dmem_ack_i),
    .dmem_req_o (w_req),
    .stall_o    (w_stall)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ex_mem_ctrl  <= '0;
      r_ex_mem_alu   <= '0;
      r_ex_mem_wdata <= '0;
      r_ex_mem_rd    <= '0;
    end else if (!w_stall) begin
      r_ex_mem_ctrl  <= w_ex_ctrl;
      r_ex_mem_alu   <= ex_alu_i;
      r_ex_mem_wdata <= ex_rs2_data_i;
      r_ex_mem_rd    <= ex_rd_i;
    end
  end

  // Load data is sampled on every advancing edge; it only matters when
  // memtoreg selects it, and on that edge the ack guarantees it is valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem_wb_ctrl <= '0;
      r_mem_wb_rd   <= '0;
      r_mem_wb_alu  <= '0;
      r_mem_wb_load <= '0;
    end else if (!w_stall) begin
      r_mem_wb_ctrl.regwrite <= r_ex_mem_ctrl.regwrite;
      r_mem_wb_ctrl.memtoreg <= r_ex_mem_ctrl.memtoreg;
      r_mem_wb_rd            <= r_ex_mem_rd;
      r_mem_wb_alu           <= r_ex_mem_alu;
      r_mem_wb_load          <= dmem_rdata_i;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_memop_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_memop_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_req && dmem_ack_i && (r_memop_cnt != '1)) begin
        r_memop_cnt <= r_memop_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign memop_cnt_o = r_memop_cnt;
`endif

  assign dmem_req_o        = w_req;
  assign dmem_we_o         = r_ex_mem_ctrl.memwrite;
  assign dmem_addr_o       = r_ex_mem_alu;
  assign dmem_wdata_o      = r_ex_mem_wdata;
  assign stall_o           = w_stall;
  assign ex_mem_regwrite_o = r_ex_mem_ctrl.regwrite;
  assign ex_mem_rd_o       = r_ex_mem_rd;
  assign ex_mem_alu_o      = r_ex_mem_alu;
  assign mem_wb_regwrite_o = r_mem_wb_ctrl.regwrite;
  assign mem_wb_rd_o       = r_mem_wb_rd;
  assign wb_data_o         = r_mem_wb_ctrl.memtoreg ? r_mem_wb_load : r_mem_wb_alu;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// tb_ex_mem_wb_pipe: self-checking bench for ex_mem_wb_pipe. A transaction-level
// model tracks which instruction sits in each pipeline slot and when the pipe
// may advance; directed scenarios are followed by randomized traffic.
`timescale 1ns/1ps
module tb_ex_mem_wb_pipe;

  typedef struct {
    bit        valid;
    bit        rw;
    bit        mtr;
    bit        mr;
    bit        mw;
    bit [31:0] alu;
    bit [31:0] wd;
    bit [4:0]  rd;
    bit [31:0] load;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        ex_valid_i = 0, ex_regwrite_i = 0, ex_memtoreg_i = 0;
  logic        ex_memread_i = 0, ex_memwrite_i = 0;
  logic [31:0] ex_alu_i = 0, ex_rs2_data_i = 0, dmem_rdata_i = 0;
  logic [4:0]  ex_rd_i = 0;
  logic        dmem_ack_i = 0;
  logic        dmem_req_o, dmem_we_o, stall_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, ex_mem_alu_o, wb_data_o;
  logic        ex_mem_regwrite_o, mem_wb_regwrite_o;
  logic [4:0]  ex_mem_rd_o, mem_wb_rd_o;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt_o, memop_cnt_o;
`endif

  always #5 clk = ~clk;

  ex_mem_wb_pipe dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .ex_valid_i        (ex_valid_i),
    .ex_regwrite_i     (ex_regwrite_i),
    .ex_memtoreg_i     (ex_memtoreg_i),
    .ex_memread_i      (ex_memread_i),
    .ex_memwrite_i     (ex_memwrite_i),
    .ex_alu_i          (ex_alu_i),
    .ex_rs2_data_i     (ex_rs2_data_i),
    .ex_rd_i           (ex_rd_i),
    .dmem_req_o        (dmem_req_o),
    .dmem_we_o         (dmem_we_o),
    .dmem_addr_o       (dmem_addr_o),
    .dmem_wdata_o      (dmem_wdata_o),
    .dmem_ack_i        (dmem_ack_i),
    .dmem_rdata_i      (dmem_rdata_i),
    .stall_o           (stall_o),
    .ex_mem_regwrite_o (ex_mem_regwrite_o),
    .ex_mem_rd_o       (ex_mem_rd_o),
    .ex_mem_alu_o      (ex_mem_alu_o),
    .mem_wb_regwrite_o (mem_wb_regwrite_o),
    .mem_wb_rd_o       (mem_wb_rd_o),
`ifdef PIPE_STALL_CNT_EN
    .stall_cnt_o       (stall_cnt_o),
    .memop_cnt_o       (memop_cnt_o),
`endif
    .wb_data_o         (wb_data_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference state: the instruction occupying each slot, plus event counts.
  instr_t m_em, m_wb;
  int     m_stall_cnt = 0;
  int     m_memop_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic instr_t bubble();
    instr_t b;
    b = '{default: 0};
    return b;
  endfunction

  function automatic instr_t mk(input bit v, input bit rw, input bit mtr, input bit mr,
                                input bit mw, input bit [31:0] alu, input bit [31:0] wd,
                                input bit [4:0] rd);
    instr_t t;
    t = '{default: 0};
    t.valid = v; t.rw = rw; t.mtr = mtr; t.mr = mr; t.mw = mw;
    t.alu = alu; t.wd = wd; t.rd = rd;
    return t;
  endfunction

  function automatic bit is_memop(input instr_t t);
    return t.valid && (t.mr || t.mw);
  endfunction

  task automatic model_reset();
    m_em = bubble();
    m_wb = bubble();
    m_stall_cnt = 0;
    m_memop_cnt = 0;
  endtask

  // One clock cycle: present inputs after the falling edge, compare every
  // output against the model, then let the model advance on the rising edge.
  task automatic step(input instr_t ex, input bit ack, input bit [31:0] rdata, output bit stalled);
    bit exp_stall;
    @(negedge clk);
    ex_valid_i = ex.valid; ex_regwrite_i = ex.rw; ex_memtoreg_i = ex.mtr;
    ex_memread_i = ex.mr; ex_memwrite_i = ex.mw; ex_alu_i = ex.alu;
    ex_rs2_data_i = ex.wd; ex_rd_i = ex.rd; dmem_ack_i = ack; dmem_rdata_i = rdata;
    #1;
    exp_stall = is_memop(m_em) && !ack;
    check("req", dmem_req_o, is_memop(m_em));
    check("stall", stall_o, exp_stall);
    check("we", dmem_we_o, m_em.valid && m_em.mw);
    check("addr", dmem_addr_o, m_em.alu);
    check("wdata", dmem_wdata_o, m_em.wd);
    check("ex_mem_rw", ex_mem_regwrite_o, m_em.valid && m_em.rw);
    check("ex_mem_rd", ex_mem_rd_o, m_em.rd);
    check("ex_mem_alu", ex_mem_alu_o, m_em.alu);
    check("mem_wb_rw", mem_wb_regwrite_o, m_wb.valid && m_wb.rw);
    check("mem_wb_rd", mem_wb_rd_o, m_wb.rd);
    check("wb_data", wb_data_o, (m_wb.valid && m_wb.mtr) ? m_wb.load : m_wb.alu);
`ifdef PIPE_STALL_CNT_EN
    check("stall_cnt", stall_cnt_o, m_stall_cnt);
    check("memop_cnt", memop_cnt_o, m_memop_cnt);
`endif
    $display("cyc %0d ex v=%0d rw=%0d mr=%0d mw=%0d rd=%0d alu=%08h ack=%0d | req=%0d stall=%0d wb_rw=%0d wb_rd=%0d wb=%08h",
             cyc, ex.valid, ex.rw, ex.mr, ex.mw, ex.rd, ex.alu, ack,
             dmem_req_o, stall_o, mem_wb_regwrite_o, mem_wb_rd_o, wb_data_o);
    stalled = stall_o;
    @(posedge clk);
    cyc++;
    if (exp_stall) begin
      m_stall_cnt++;
    end else begin
      if (is_memop(m_em)) m_memop_cnt++;
      m_wb = m_em;
      m_wb.load = rdata;
      m_em = ex;
    end
  endtask

  initial begin
    instr_t b, t;
    bit     s;
    int     nstall;
    int     waited;
    int     dly;
    b = bubble();
    model_reset();

    // Reset state.
    #2;
    check("rst_req", dmem_req_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_wb_rw", mem_wb_regwrite_o, 0);
    @(negedge clk);
    rst_i = 1'b0;

    // ALU op, zero-wait.
    step(mk(1, 1, 0, 0, 0, 32'h0000_00AA, 0, 5), 0, 0, s);
    step(b, 0, 0, s);
    check("alu_exmem_rd", ex_mem_rd_o, 5);
    step(b, 0, 0, s);
    check("alu_wb_data", wb_data_o, 32'hAA);

    // Load to x7 with a 3-cycle acknowledge delay.
    nstall = 0;
    step(mk(1, 1, 1, 1, 0, 32'h100, 0, 7), 0, 0, s);
    for (int i = 0; i < 3; i++) begin
      step(b, 0, $urandom, s);
      nstall += s;
    end
    step(b, 1, 32'hDEAD_BEEF, s);
    nstall += s;
    check("load_stall_cycles", nstall, 3);
    step(b, 0, 0, s);
    check("load_wb_rd", mem_wb_rd_o, 7);
    check("load_wb_data", wb_data_o, 32'hDEAD_BEEF);

    // Store, same-cycle acknowledge, no register write.
    step(mk(1, 0, 0, 0, 1, 32'h40, 32'h1234, 9), 0, 0, s);
    step(b, 1, 0, s);
    check("store_no_stall", s, 0);
    step(b, 0, 0, s);
    check("store_wb_rw", mem_wb_regwrite_o, 0);

    // Bubble carrying regwrite must not write.
    step(mk(0, 1, 0, 0, 0, 32'h33, 0, 3), 0, 0, s);
    step(b, 0, 0, s);
    check("bubble_exmem_rw", ex_mem_regwrite_o, 0);
    step(b, 0, 0, s);
    check("bubble_wb_rw", mem_wb_regwrite_o, 0);

    // Reset pulsed while waiting for an acknowledge.
    step(mk(1, 1, 1, 1, 0, 32'h200, 0, 4), 0, 0, s);
    step(b, 0, 0, s);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    check("midwait_rst_req", dmem_req_o, 0);
    check("midwait_rst_stall", stall_o, 0);
    model_reset();
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("post_rst_exmem_rw", ex_mem_regwrite_o, 0);
    check("post_rst_wb_rw", mem_wb_regwrite_o, 0);

    // Two loads with a 2-cycle acknowledge delay each.
    step(mk(1, 1, 1, 1, 0, 32'h300, 0, 1), 0, 0, s);
    step(b, 0, 0, s);
    step(b, 0, 0, s);
    step(mk(1, 1, 1, 1, 0, 32'h304, 0, 2), 1, 32'h1111, s);
    step(b, 0, 0, s);
    step(b, 0, 0, s);
    step(b, 1, 32'h2222, s);
    step(b, 0, 0, s);
    check("two_loads_wb", wb_data_o, 32'h2222);
`ifdef PIPE_STALL_CNT_EN
    check("two_loads_stall_cnt", stall_cnt_o, 4);
    check("two_loads_memop_cnt", memop_cnt_o, 2);
`endif

    // Randomized traffic with random acknowledge delays and stray acks.
    waited = 0;
    dly = $urandom_range(0, 3);
    for (int i = 0; i < 300; i++) begin
      bit ack;
      int kind;
      kind = $urandom_range(0, 3);
      t = mk($urandom_range(0, 3) != 0, $urandom, $urandom, kind == 1, kind == 2,
             $urandom, $urandom, $urandom);
      if (kind == 1) t.mtr = 1;
      if (is_memop(m_em)) ack = (waited >= dly);
      else ack = ($urandom_range(0, 3) == 0);
      step(t, ack, $urandom, s);
      if (s) begin
        waited++;
      end else begin
        waited = 0;
        dly = $urandom_range(0, 3);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Guard against a hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_mem_wb_pipe.md
Name: ex_mem_wb_pipe

Overview:
- Holds the EX/MEM and MEM/WB pipeline registers of the 5-stage RV32 core, and runs the data-memory access handshake.
- Produces the RegWrite/Rd pairs that the forwarding unit consumes, the EX-side forward data, and the write-back data.
- Freezes the whole pipeline while a load/store waits for its memory acknowledge.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register index width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- ex_valid_i  in  1  EX holds a real instruction (0 = bubble)
- ex_regwrite_i  in  1  instruction writes rd
- ex_memtoreg_i  in  1  write-back source is load data
- ex_memread_i  in  1  load
- ex_memwrite_i  in  1  store
- ex_alu_i  in  XLEN  ALU result / memory address
- ex_rs2_data_i  in  XLEN  forwarded store data
- ex_rd_i  in  REG_AW  destination register
- dmem_req_o  out  1  memory request, held until ack
- dmem_we_o  out  1  store when 1
- dmem_addr_o  out  XLEN  equals EX/MEM ALU result
- dmem_wdata_o  out  XLEN  EX/MEM store data
- dmem_ack_i  in  1  request completes this cycle; rdata valid
- dmem_rdata_i  in  XLEN  load data
- stall_o  out  1  freeze IF/ID/EX (PC, IF/ID, ID/EX hold)
- ex_mem_regwrite_o  out  1  to forwarding unit
- ex_mem_rd_o  out  REG_AW  to forwarding unit
- ex_mem_alu_o  out  XLEN  forward path "10"
- mem_wb_regwrite_o  out  1  to forwarding unit and register file
- mem_wb_rd_o  out  REG_AW  to forwarding unit and register file
- wb_data_o  out  XLEN  forward path "01" and register-file write data

Behaviour:
- Reset (async, rst_i=1):
  - all valid/regwrite/memread/memwrite/memtoreg flops clear; data and rd flops clear to 0.
  - FSM goes to IDLE; dmem_req_o=0 and stall_o=0 immediately.
- EX/MEM register:
  - Captures ex_* on the clock edge when stall_o=0.
  - Control bits are ANDed with ex_valid_i, so a bubble stores regwrite=0, memread=0, memwrite=0.
- MEM/WB register:
  - Captures on the clock edge when stall_o=0: regwrite, rd, memtoreg, ALU result, and load data (dmem_rdata_i).
- wb_data_o = mem_wb_memtoreg ? mem_wb_load : mem_wb_alu. Combinational from flops.
- memop = EX/MEM memread | memwrite.
- FSM, states IDLE and WAIT:
  - IDLE with memop=0: dmem_req_o=0, stall_o=0.
  - IDLE with memop=1: dmem_req_o=1.
    - ack=1: stall_o=0, pipeline advances, stay IDLE.
    - ack=0: stall_o=1, go to WAIT.
  - WAIT: dmem_req_o=1, dmem_we_o, addr and wdata stable, stall_o = ~dmem_ack_i.
    - On ack: advance, go to IDLE.
- Latency:
  - Zero-wait memory: one cycle per stage, no stall.
  - N-cycle ack: N stall cycles.
- During a stall, both registers hold. MEM/WB keeps its regwrite, so the register file rewrites the same value each cycle (idempotent).
- Back-to-back memops: a new memop entering EX/MEM on the ack edge starts in IDLE and raises req the next cycle. No dead cycle beyond the handshake.
- A store never writes MEM/WB regwrite unless ex_regwrite_i was set; it is stored exactly as given.
- rd=0 is stored unfiltered; x0 filtering is the consumer's job.
- dmem_ack_i while dmem_req_o=0: ignored.
- Reset asserted during WAIT: request dropped, no pending state survives.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o [31:0], an event counter incremented each cycle stall_o=1.
  - Adds output memop_cnt_o [31:0], incremented on each completed ack.
  - Both saturate at all-ones and clear on reset.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (pipe_pkg), holding:
  - XLEN and REG_AW constants.
  - A struct for EX/MEM control {regwrite, memtoreg, memread, memwrite}.
  - A struct for MEM/WB control {regwrite, memtoreg}.
  - The FSM state enum {IDLE, WAIT}.
- One sub-module is natural: dmem_handshake_fsm.
  - Inputs: memop, dmem_ack_i.
  - Outputs: dmem_req_o, stall_o.
- The pipeline registers stay in the top.

Test Plan:
- Reset release, then an ALU op with rd=5, ALU result 0x0000_00AA, zero-wait: ex_mem_rd_o=5 and regwrite=1 at cycle 1. Cycle 2: mem_wb_rd_o=5, wb_data_o=0xAA. stall_o stays 0.
- Load to rd=7 at address 0x100, ack delayed 3 cycles, rdata 0xDEAD_BEEF:
  - stall_o=1 for exactly 3 cycles; req, addr 0x100 and we=0 stable throughout; EX/MEM and MEM/WB unchanged.
  - Then wb_data_o=0xDEAD_BEEF with mem_wb_rd_o=7.
- Store to 0x40 with data 0x1234, ack in the same cycle: dmem_we_o=1, wdata 0x1234, no stall. MEM/WB regwrite=0.
- ex_valid_i=0 with ex_regwrite_i=1 and rd=3: ex_mem_regwrite_o=0, and one cycle later mem_wb_regwrite_o=0.
- rst_i pulsed mid-WAIT: dmem_req_o and stall_o drop asynchronously. After release, FSM is IDLE and all regwrite outputs are 0.
- With PIPE_STALL_CNT_EN defined, two loads each with 2-cycle ack delay: stall_cnt_o=4, memop_cnt_o=2.
